// File: rtl/tone_seq_if.sv
// Handshake bundle between the purchase logic and the melody sequencer.
// The requester drives buy_req; the sequencer drives the beeper-side outputs.
interface tone_seq_if;
  logic       buy_req;
  logic       flag_buying;
  logic       status;
  logic       busy;
  logic [3:0] note_idx;

  modport master (
    output buy_req,
    input  flag_buying,
    input  status,
    input  busy,
    input  note_idx
  );

  modport slave (
    input  buy_req,
    output flag_buying,
    output status,
    output busy,
    output note_idx
  );
endinterface

// File: rtl/tone_seq.sv
// Purchase-melody sequencer: on a rising buy_req it pulses flag_buying and
// plays a fixed note table as a square wave on status (1 = silent beeper).
module tone_seq #(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned NUM_NOTES   = 10,
  parameter int unsigned HALF_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  tone_seq_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  localparam logic [24:0] NCNT_LAST = 25'(NOTE_CYCLES - 1);
  localparam logic [3:0]  NOTE_LAST = 4'(NUM_NOTES - 1);

  // Half-periods in cycles; 0 is a rest. Padded to 16 so any 4-bit index is safe.
  localparam logic [15:0] NOTE_TABLE [16] = '{
    16'd47801, 16'd37936, 16'd31887, 16'd23889, 16'd0,
    16'd31887, 16'd37936, 16'd47801, 16'd31887, 16'd23889,
    16'd0,     16'd0,     16'd0,     16'd0,     16'd0,     16'd0
  };

  logic [15:0] half_tab [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_half
      assign half_tab[gi] = NOTE_TABLE[gi] >> HALF_SHIFT;
    end
  endgenerate

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        flag_buying_q, flag_buying_d;
  logic        status_q, status_d;
  logic        busy_q, busy_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic [24:0] ncnt_q, ncnt_d;
  logic [15:0] hcnt_q, hcnt_d;

  logic        trigger;
  logic [15:0] half;
  logic [15:0] hcnt_inc;

  always_comb begin
    trigger  = bus.buy_req & ~req_q;
    half     = half_tab[note_idx_q];
    hcnt_inc = hcnt_q + 16'd1;

    state_d       = state_q;
    req_d         = bus.buy_req;
    flag_buying_d = 1'b0;
    status_d      = status_q;
    busy_d        = busy_q;
    note_idx_d    = note_idx_q;
    ncnt_d        = ncnt_q;
    hcnt_d        = hcnt_q;

    if (trigger) begin
      // A trigger restarts the melody from the top whether idle or playing.
      state_d       = PLAY;
      flag_buying_d = 1'b1;
      busy_d        = 1'b1;
      status_d      = 1'b1;
      note_idx_d    = 4'd0;
      ncnt_d        = '0;
      hcnt_d        = '0;
    end else if (state_q == PLAY) begin
      if (ncnt_q == NCNT_LAST) begin
        ncnt_d   = '0;
        hcnt_d   = '0;
        status_d = 1'b1;
        if (note_idx_q < NOTE_LAST) begin
          note_idx_d = note_idx_q + 4'd1;
        end else begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          note_idx_d = 4'd0;
        end
      end else begin
        ncnt_d = ncnt_q + 25'd1;
        // hcnt counts cycles spent in the current half-period; the toggle
        // lands on the cycle that completes it, so each level lasts H cycles.
        if (half == 16'd0) begin
          status_d = 1'b1;
          hcnt_d   = '0;
        end else if (hcnt_inc == half) begin
          status_d = ~status_q;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_inc;
        end
      end
    end else begin
      status_d   = 1'b1;
      busy_d     = 1'b0;
      note_idx_d = 4'd0;
      ncnt_d     = '0;
      hcnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      flag_buying_q <= 1'b0;
      status_q      <= 1'b1;
      busy_q        <= 1'b0;
      note_idx_q    <= 4'd0;
      ncnt_q        <= '0;
      hcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      flag_buying_q <= flag_buying_d;
      status_q      <= status_d;
      busy_q        <= busy_d;
      note_idx_q    <= note_idx_d;
      ncnt_q        <= ncnt_d;
      hcnt_q        <= hcnt_d;
    end
  end

  assign bus.flag_buying = flag_buying_q;
  assign bus.status      = status_q;
  assign bus.busy        = busy_q;
  assign bus.note_idx    = note_idx_q;

endmodule

// File: doc/tone_seq.md
# tone_seq

Purchase-melody sequencer sitting directly upstream of the beeper driver. On a purchase request it emits the one-cycle `flag_buying` restart pulse and then drives `status` with a square-wave melody from a fixed 10-entry note table. The beeper driver consumes both signals. `status` low sounds the active-low beeper, and `status` high keeps it silent. Total melody length is 250,000,000 cycles at the defaults, matching the driver's 5 s music window at 50 MHz.

## Interface
- `NOTE_CYCLES`, default 25_000_000: duration of each note in clock cycles (1–2^25−1).
- `NUM_NOTES`, default 10: number of table entries played (1–10).
- `HALF_SHIFT`, default 0: right-shift applied to every table half-period, for simulation scaling only (0–8).
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `buy_req` in 1: purchase request, level; a 0→1 transition triggers playback.
- `flag_buying` out 1: one-cycle restart pulse to the beeper driver.
- `status` out 1: tone square wave; 1 means silent.
- `busy` out 1: melody in progress.
- `note_idx` out 4: index of the note currently playing; 0 when idle.

## Operation
- Note table: entry 0 = 0 means a rest; any other value is a half-period in cycles, then shifted right by `HALF_SHIFT`.
- Table entries 0–9, in order:
  - 0: 47801 (C5)
  - 1: 37936 (E5)
  - 2: 31887 (G5)
  - 3: 23889 (C6)
  - 4: 0 (rest)
  - 5: 31887 (G5)
  - 6: 37936 (E5)
  - 7: 47801 (C5)
  - 8: 31887 (G5)
  - 9: 23889 (C6)
- Two states: IDLE and PLAY.
- Edge detect: register `buy_req` into `req_d`. A trigger is `buy_req & ~req_d`. `req_d` resets to 0, so a `buy_req` already high at reset release counts as an edge.
- IDLE:
  - `status`=1, `busy`=0, `note_idx`=0, all counters 0.
  - On trigger → PLAY.
- PLAY:
  - Note counter `ncnt` (25 bits) counts 0..`NOTE_CYCLES`−1.
  - Half-period counter `hcnt` (16 bits) counts 1..H, where H is the current entry after the shift.
  - When `hcnt` reaches H: toggle `status` and set `hcnt` to 1.
  - If H=0, `status` is held at 1 and `hcnt` is held at 0.
  - When `ncnt` = `NOTE_CYCLES`−1:
    - if `note_idx` < `NUM_NOTES`−1: increment `note_idx`, clear `ncnt` and `hcnt`, force `status`=1;
    - otherwise go to IDLE (`busy`=0, `status`=1, `note_idx`=0).
- Retrigger in PLAY: the melody restarts exactly as from IDLE. `note_idx`, `ncnt` and `hcnt` clear, `status` is forced to 1, and `flag_buying` pulses again.
- `flag_buying` is registered. It is 1 for exactly the cycle after each trigger and 0 otherwise.
- All outputs are registered. Reset values: `flag_buying`=0, `status`=1, `busy`=0, `note_idx`=0.

## Timing
- Trigger sampled at edge t (`buy_req`=1, `req_d`=0). In cycle t+1: `flag_buying`=1, `busy`=1, `note_idx`=0, `status`=1.
- First `status` fall: H cycles after t+1 for note 0. Afterwards `status` toggles every H cycles, giving period 2H.
- Each note occupies exactly `NOTE_CYCLES` cycles from its first cycle. `busy` is high for exactly `NUM_NOTES`×`NOTE_CYCLES` cycles per uninterrupted melody.
- Note boundary:
  - `note_idx` increments and `status`=1 in the same cycle;
  - the next note's first toggle comes H' cycles later, where H' is the next entry's half-period.
- Reset is synchronous. If `rst_n`=0 at an edge mid-melody, all outputs take their reset values after that edge and no `flag_buying` is issued. `buy_req` held high through reset release is a trigger at the first edge with `rst_n`=1.
- Trigger coinciding with the final cycle of the melody: the retrigger wins. `busy` stays 1 and the melody restarts.
- `buy_req` held high produces a single trigger; a new trigger needs a 0 then a 1.

## Test plan
Bench parameters unless stated otherwise: `NOTE_CYCLES`=1000, `HALF_SHIFT`=8.
- Idle/reset: hold `rst_n`=0 for 5 cycles, then release with `buy_req`=0 → `status`=1, `busy`=0, `flag_buying`=0, `note_idx`=0 held for 100 cycles.
- Single melody: 1-cycle `buy_req` pulse → `flag_buying` high for exactly 1 cycle, the cycle after the pulse.
  - `busy` high for exactly 10,000 cycles.
  - Note 0 half-period is 186 cycles (47801>>8); first `status` fall 186 cycles after the `flag_buying` cycle.
  - Note 4 keeps `status`=1 for all 1000 cycles.
  - `note_idx` steps 0→9 every 1000 cycles, then returns to 0.
- Retrigger: second pulse at cycle 2500 of the melody → second `flag_buying` pulse; `note_idx`=0 the next cycle; `busy` continuous; melody ends 10,000 cycles after the second pulse.
- Held request: `buy_req` held high for 20,000 cycles → exactly one `flag_buying` pulse and one 10,000-cycle melody.
- Mid-melody reset: `rst_n`=0 for 1 cycle during note 3 → next cycle `status`=1, `busy`=0, `note_idx`=0; no `flag_buying` pulse.
- End-boundary retrigger: trigger on the last busy cycle → `busy` never drops and `flag_buying` pulses once.
